// File: rtl/stall_fifo.sv
// Stallable, flushable FIFO pipeline stage with registered storage.
// There is no bypass path, so data pushed into an empty buffer is
// presented one cycle later. ready_out depends only on local state,
// stall and flush, and never on ready_in.
module stall_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ready_in,
   input  logic             valid_in,
   input  logic             stall,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready_out,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   // Handshake and status outputs, derived only from registered state and controls.
   always_comb begin
      full      = (count_q == DepthCnt);
      empty     = (count_q == '0);
      ready_out = !stall && !flush && !full;
      valid_out = !stall && !flush && !empty;
      push      = valid_in && ready_out;
      pop       = valid_out && ready_in;
      data_out  = mem_q[rd_ptr_q];
      count     = count_q;
   end

   // Next pointer and occupancy; flush wins over everything else.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; cleared on reset so data_out reads zero while empty after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !flush) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_stall_fifo.sv
// Directed self-checking bench for stall_fifo: an 8x3 instance for the main
// scenarios and a 1x1 instance for the single-entry throughput case.
module tb_stall_fifo;

   logic       clk;
   logic       rst_n;
   logic       ready_in, valid_in, stall, flush;
   logic [7:0] data_in;
   logic       ready_out, valid_out, full, empty;
   logic [7:0] data_out;
   logic [1:0] count;

   logic       b_ready_in, b_valid_in, b_stall, b_flush;
   logic [0:0] b_data_in;
   logic       b_ready_out, b_valid_out, b_full, b_empty;
   logic [0:0] b_data_out;
   logic [0:0] b_count;

   int n_tests;
   int n_fail;

   stall_fifo #(.WIDTH(8), .DEPTH(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ready_in  (ready_in),
      .valid_in  (valid_in),
      .stall     (stall),
      .flush     (flush),
      .data_in   (data_in),
      .ready_out (ready_out),
      .valid_out (valid_out),
      .data_out  (data_out),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   stall_fifo #(.WIDTH(1), .DEPTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .ready_in  (b_ready_in),
      .valid_in  (b_valid_in),
      .stall     (b_stall),
      .flush     (b_flush),
      .data_in   (b_data_in),
      .ready_out (b_ready_out),
      .valid_out (b_valid_out),
      .data_out  (b_data_out),
      .count     (b_count),
      .full      (b_full),
      .empty     (b_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hold(input logic [7:0] d);
      valid_in = 1'b1;
      data_in  = d;
      cyc();
      valid_in = 1'b0;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      ready_in   = 1'b0;
      valid_in   = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      data_in    = 8'h00;
      b_ready_in = 1'b0;
      b_valid_in = 1'b0;
      b_stall    = 1'b0;
      b_flush    = 1'b0;
      b_data_in  = 1'b0;

      // Reset state
      #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 8'h00);
      check("rst_ready", ready_out, 1);
      stall = 1'b1;
      #1;
      check("rst_ready_stall", ready_out, 0);
      stall = 1'b0;
      // No push may land while reset is held, even across an edge
      valid_in = 1'b1;
      data_in  = 8'hEE;
      cyc();
      check("rst_no_push", count, 0);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b1;
      cyc();

      // Fill to full with downstream blocked, then drain
      ready_in = 1'b0;
      valid_in = 1'b1;
      data_in  = 8'h11;
      #1;
      check("fill_ready0", ready_out, 1);
      check("fill_valid0", valid_out, 0);
      cyc();
      check("fill_cnt1", count, 1);
      data_in = 8'h22;
      cyc();
      check("fill_cnt2", count, 2);
      data_in = 8'h33;
      cyc();
      check("fill_cnt3", count, 3);
      check("fill_full", full, 1);
      data_in  = 8'h44;
      ready_in = 1'b1;
      #1;
      check("full_no_refill", ready_out, 0);
      check("drain_d0", data_out, 8'h11);
      cyc();
      valid_in = 1'b0;
      #1;
      check("drain_cnt2", count, 2);
      check("drain_d1", data_out, 8'h22);
      cyc();
      check("drain_d2", data_out, 8'h33);
      cyc();
      check("drain_empty", empty, 1);
      check("drain_valid", valid_out, 0);

      // Streaming: output trails input by one cycle, count stays 1
      ready_in = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         data_in = 8'(8'h40 + i);
         #1;
         if (i > 0) begin
            check("stream_data", data_out, 8'(8'h40 + i - 1));
            check("stream_cnt", count, 1);
         end
         cyc();
      end
      valid_in = 1'b0;
      #1;
      check("stream_last", data_out, 8'h53);
      cyc();
      check("stream_empty", empty, 1);

      // Stall freezes a 2-entry buffer
      ready_in = 1'b0;
      push_hold(8'h61);
      push_hold(8'h62);
      stall    = 1'b1;
      valid_in = 1'b1;
      ready_in = 1'b1;
      data_in  = 8'h99;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("stall_ready", ready_out, 0);
         check("stall_valid", valid_out, 0);
         check("stall_cnt", count, 2);
         cyc();
      end
      stall    = 1'b0;
      valid_in = 1'b0;
      #1;
      check("unstall_d0", data_out, 8'h61);
      check("unstall_v0", valid_out, 1);
      cyc();
      check("unstall_d1", data_out, 8'h62);
      cyc();
      check("unstall_empty", empty, 1);

      // Flush beats stall and push
      ready_in = 1'b0;
      push_hold(8'h71);
      push_hold(8'h72);
      push_hold(8'h73);
      flush    = 1'b1;
      stall    = 1'b1;
      valid_in = 1'b1;
      data_in  = 8'h77;
      #1;
      check("flush_ready", ready_out, 0);
      cyc();
      flush    = 1'b0;
      stall    = 1'b0;
      valid_in = 1'b0;
      #1;
      check("flush_cnt", count, 0);
      check("flush_empty", empty, 1);
      push_hold(8'hAB);
      ready_in = 1'b1;
      #1;
      check("flush_next_v", valid_out, 1);
      check("flush_next_d", data_out, 8'hAB);
      cyc();
      check("flush_next_empty", empty, 1);

      // Asynchronous reset mid-operation
      ready_in = 1'b0;
      push_hold(8'h81);
      push_hold(8'h82);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", valid_out, 0);
      check("arst_data", data_out, 8'h00);
      check("arst_cnt", count, 0);
      rst_n = 1'b1;
      cyc();
      push_hold(8'h5A);
      ready_in = 1'b1;
      #1;
      check("arst_next_v", valid_out, 1);
      check("arst_next_d", data_out, 8'h5A);
      cyc();
      ready_in = 1'b0;

      // Single-entry instance: one item per two cycles, alternating data 1,0,1,0
      b_ready_in = 1'b1;
      b_valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b_data_in = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
         #1;
         if (i % 2 == 0) begin
            check("d1_ready_hi", b_ready_out, 1);
            check("d1_valid_lo", b_valid_out, 0);
         end else begin
            check("d1_ready_lo", b_ready_out, 0);
            check("d1_valid_hi", b_valid_out, 1);
            check("d1_data", b_data_out, ((i / 2) % 2 == 0) ? 1 : 0);
         end
         cyc();
      end
      b_valid_in = 1'b0;
      #1;
      check("d1_empty", b_empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
